// File: rtl/gf13_pkg.sv
// GF(2^13) field constants and elaboration-time helpers.
// Matrices for constant multipliers are derived here from exponents only.
package gf13_pkg;

  localparam int M = 13;
  localparam logic [M-1:0] POLY = 13'h001B;
  localparam int N = 8191;

  typedef logic [M-1:0] gf_t;
  typedef logic [M-1:0][M-1:0] mat_t;

  function automatic gf_t mul_x(input gf_t a);
    return {a[M-2:0], 1'b0} ^ (a[M-1] ? POLY : '0);
  endfunction

  function automatic gf_t gf_mul(input gf_t a, input gf_t b);
    gf_t r;
    r = '0;
    for (int i = M - 1; i >= 0; i--) begin
      r = mul_x(r);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  // Square-and-multiply keeps elaboration loops short.
  function automatic gf_t alpha_pow(input int e);
    int k;
    gf_t r;
    gf_t base;
    k = e % N;
    r = gf_t'(1);
    base = gf_t'(2);
    for (int i = 0; i < M; i++) begin
      if (k[i]) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  function automatic mat_t const_mul_matrix(input int e);
    mat_t m;
    for (int c = 0; c < M; c++) m[c] = alpha_pow(e + c);
    return m;
  endfunction

endpackage

// File: rtl/gf13_const_mul.sv
// Constant multiplier c = a * alpha^E over GF(2^13).
// Each output bit is an XOR of a fixed subset of input bits.
module gf13_const_mul
  import gf13_pkg::*;
#(
  parameter int E = 1
) (
  input  logic [M-1:0] a,
  output logic [M-1:0] c
);

  localparam mat_t MAT = const_mul_matrix(E);

  always_comb begin
    c = '0;
    for (int k = 0; k < M; k++) begin
      if (a[k]) c = c ^ MAT[k];
    end
  end

endmodule

// File: rtl/multiplier_column_p16.sv
// Combinational column bindings for columns 1..3 of the Chien search.
// Clock, reset and enable are tied off since nothing is registered.
module multiplier_column1_p16
  import gf13_pkg::*;
(
  input  logic [M-1:0] b,
  output logic [M-1:0] P1, P2, P3, P4, P5, P6, P7, P8,
  output logic [M-1:0] P9, P10, P11, P12, P13, P14, P15, P16
);
  chien_const_mul_column #(.COL(1), .REG_OUT(1'b0)) u_col (
    .clk(1'b0), .reset(1'b0), .en(1'b0), .*
  );
endmodule

module multiplier_column2_p16
  import gf13_pkg::*;
(
  input  logic [M-1:0] b,
  output logic [M-1:0] P1, P2, P3, P4, P5, P6, P7, P8,
  output logic [M-1:0] P9, P10, P11, P12, P13, P14, P15, P16
);
  chien_const_mul_column #(.COL(2), .REG_OUT(1'b0)) u_col (
    .clk(1'b0), .reset(1'b0), .en(1'b0), .*
  );
endmodule

module multiplier_column3_p16
  import gf13_pkg::*;
(
  input  logic [M-1:0] b,
  output logic [M-1:0] P1, P2, P3, P4, P5, P6, P7, P8,
  output logic [M-1:0] P9, P10, P11, P12, P13, P14, P15, P16
);
  chien_const_mul_column #(.COL(3), .REG_OUT(1'b0)) u_col (
    .clk(1'b0), .reset(1'b0), .en(1'b0), .*
  );
endmodule

// File: rtl/chien_const_mul_column.sv
// One Chien search column: sixteen products b*alpha^(COL*i), i=1..16.
// Optional output register bank; the feedback loop needs REG_OUT=0.
module chien_const_mul_column
  import gf13_pkg::*;
#(
  parameter int COL = 1,
  parameter bit REG_OUT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic [M-1:0] b,
  output logic [M-1:0] P1,
  output logic [M-1:0] P2,
  output logic [M-1:0] P3,
  output logic [M-1:0] P4,
  output logic [M-1:0] P5,
  output logic [M-1:0] P6,
  output logic [M-1:0] P7,
  output logic [M-1:0] P8,
  output logic [M-1:0] P9,
  output logic [M-1:0] P10,
  output logic [M-1:0] P11,
  output logic [M-1:0] P12,
  output logic [M-1:0] P13,
  output logic [M-1:0] P14,
  output logic [M-1:0] P15,
  output logic [M-1:0] P16
);

  logic [15:0][M-1:0] prod;
  logic [15:0][M-1:0] q;

  for (genvar i = 0; i < 16; i++) begin : g_mul
    gf13_const_mul #(
      .E(COL * (i + 1))
    ) u_mul (
      .a(b),
      .c(prod[i])
    );
  end

  if (REG_OUT) begin : g_reg
    always_ff @(posedge clk) begin
      if (reset) q <= '0;
      else if (en) q <= prod;
    end
  end else begin : g_comb
    logic unused;
    assign unused = ^{clk, reset, en};
    assign q = prod;
  end

  assign P1  = q[0];
  assign P2  = q[1];
  assign P3  = q[2];
  assign P4  = q[3];
  assign P5  = q[4];
  assign P6  = q[5];
  assign P7  = q[6];
  assign P8  = q[7];
  assign P9  = q[8];
  assign P10 = q[9];
  assign P11 = q[10];
  assign P12 = q[11];
  assign P13 = q[12];
  assign P14 = q[13];
  assign P15 = q[14];
  assign P16 = q[15];

endmodule

// File: tb/tb_chien_const_mul_column.sv
// Bench for chien_const_mul_column: combinational columns 1..3
// and a registered column 1, against a shift-and-reduce model.
module tb_chien_const_mul_column;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic [12:0] bc;
  logic [12:0] br;
  logic [12:0] q1 [1:16];
  logic [12:0] q2 [1:16];
  logic [12:0] q3 [1:16];
  logic [12:0] qr [1:16];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chien_const_mul_column #(.COL(1), .REG_OUT(1'b0)) u_c1 (
    .clk(clk), .reset(reset), .en(en), .b(bc),
    .P1(q1[1]), .P2(q1[2]), .P3(q1[3]), .P4(q1[4]),
    .P5(q1[5]), .P6(q1[6]), .P7(q1[7]), .P8(q1[8]),
    .P9(q1[9]), .P10(q1[10]), .P11(q1[11]), .P12(q1[12]),
    .P13(q1[13]), .P14(q1[14]), .P15(q1[15]), .P16(q1[16])
  );

  chien_const_mul_column #(.COL(2), .REG_OUT(1'b0)) u_c2 (
    .clk(clk), .reset(reset), .en(en), .b(bc),
    .P1(q2[1]), .P2(q2[2]), .P3(q2[3]), .P4(q2[4]),
    .P5(q2[5]), .P6(q2[6]), .P7(q2[7]), .P8(q2[8]),
    .P9(q2[9]), .P10(q2[10]), .P11(q2[11]), .P12(q2[12]),
    .P13(q2[13]), .P14(q2[14]), .P15(q2[15]), .P16(q2[16])
  );

  chien_const_mul_column #(.COL(3), .REG_OUT(1'b0)) u_c3 (
    .clk(clk), .reset(reset), .en(en), .b(bc),
    .P1(q3[1]), .P2(q3[2]), .P3(q3[3]), .P4(q3[4]),
    .P5(q3[5]), .P6(q3[6]), .P7(q3[7]), .P8(q3[8]),
    .P9(q3[9]), .P10(q3[10]), .P11(q3[11]), .P12(q3[12]),
    .P13(q3[13]), .P14(q3[14]), .P15(q3[15]), .P16(q3[16])
  );

  chien_const_mul_column #(.COL(1), .REG_OUT(1'b1)) u_r1 (
    .clk(clk), .reset(reset), .en(en), .b(br),
    .P1(qr[1]), .P2(qr[2]), .P3(qr[3]), .P4(qr[4]),
    .P5(qr[5]), .P6(qr[6]), .P7(qr[7]), .P8(qr[8]),
    .P9(qr[9]), .P10(qr[10]), .P11(qr[11]), .P12(qr[12]),
    .P13(qr[13]), .P14(qr[14]), .P15(qr[15]), .P16(qr[16])
  );

  task automatic chk(input string tag, input logic [12:0] got,
                     input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] xt(input logic [12:0] a);
    return {a[11:0], 1'b0} ^ (a[12] ? 13'h001B : 13'h0000);
  endfunction

  function automatic logic [12:0] mref(input logic [12:0] a, input int e);
    logic [12:0] r;
    r = a;
    for (int k = 0; k < e; k++) r = xt(r);
    return r;
  endfunction

  function automatic logic [12:0] pget(input int col, input int i);
    case (col)
      1: return q1[i];
      2: return q2[i];
      default: return q3[i];
    endcase
  endfunction

  logic [12:0] s1 [1:3][1:16];
  logic [12:0] s2 [1:3][1:16];
  logic [12:0] exp13 [1:16];
  logic [12:0] b1, b2, v, v511;
  int first_ret;

  initial begin
    reset = 1'b1;
    en = 1'b0;
    br = 13'h0000;
    bc = 13'h0001;
    #1;
    for (int i = 1; i <= 12; i++) exp13[i] = 13'(1 << i);
    exp13[13] = 13'h001B;
    exp13[14] = 13'h0036;
    exp13[15] = 13'h006C;
    exp13[16] = 13'h00D8;
    for (int i = 1; i <= 16; i++)
      chk($sformatf("c1_unit_p%0d", i), q1[i], exp13[i]);
    chk("c2_unit_p6", q2[6], 13'h1000);
    chk("c2_unit_p7", q2[7], 13'h0036);
    chk("c2_unit_p8", q2[8], 13'h00D8);
    chk("c2_unit_p16", q2[16], 13'h1176);
    chk("c3_unit_p4", q3[4], 13'h1000);
    chk("c3_unit_p5", q3[5], 13'h006C);
    bc = 13'h1000;
    #1;
    chk("c1_x12_p1", q1[1], 13'h001B);
    bc = 13'h0000;
    #1;
    for (int c = 1; c <= 3; c++)
      for (int i = 1; i <= 16; i++)
        chk($sformatf("zero_c%0d_p%0d", c, i), pget(c, i), 13'h0000);

    for (int t = 0; t < 6; t++) begin
      b1 = 13'($urandom);
      b2 = 13'($urandom);
      bc = b1;
      #1;
      for (int c = 1; c <= 3; c++)
        for (int i = 1; i <= 16; i++) begin
          s1[c][i] = pget(c, i);
          chk($sformatf("ref_b1_c%0d_p%0d", c, i), s1[c][i],
              mref(b1, c * i));
        end
      bc = b2;
      #1;
      for (int c = 1; c <= 3; c++)
        for (int i = 1; i <= 16; i++) begin
          s2[c][i] = pget(c, i);
          chk($sformatf("ref_b2_c%0d_p%0d", c, i), s2[c][i],
              mref(b2, c * i));
        end
      bc = b1 ^ b2;
      #1;
      for (int c = 1; c <= 3; c++)
        for (int i = 1; i <= 16; i++)
          chk($sformatf("lin_c%0d_p%0d", c, i), pget(c, i),
              s1[c][i] ^ s2[c][i]);
    end

    // alpha^16 has order 8191, so the P16 loop first returns at 8191.
    v = 13'h0001;
    first_ret = 0;
    v511 = 13'h0000;
    for (int s = 1; s <= 8191; s++) begin
      bc = v;
      #1;
      v = q1[16];
      if (s == 511) v511 = v;
      if (v == 13'h0001 && first_ret == 0) first_ret = s;
    end
    chk("loop_511", v511, mref(13'h0001, 511 * 16));
    chk("loop_period", 13'(first_ret), 13'(8191));

    @(negedge clk);
    reset = 1'b1;
    en = 1'b1;
    br = 13'h0001;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("r_rst_p1", qr[1], 13'h0000);
    chk("r_rst_p16", qr[16], 13'h0000);
    @(negedge clk);
    reset = 1'b0;
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("r_noen_p1", qr[1], 13'h0000);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("r_load_p1", qr[1], 13'h0002);
    chk("r_load_p16", qr[16], 13'h00D8);
    @(negedge clk);
    en = 1'b0;
    br = 13'h0003;
    @(posedge clk);
    #1;
    chk("r_hold_p1", qr[1], 13'h0002);
    chk("r_hold_p13", qr[13], 13'h001B);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("r_load3_p1", qr[1], 13'h0006);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("r_midrst_p1", qr[1], 13'h0000);
    chk("r_midrst_p16", qr[16], 13'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
